fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch-packet entries; SHALL be a power of two, at least 2.
REQ-002 clock_i  input  1  sole clock; all state updates on posedge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 fetch_valid_i  input  1  fetch packet presented this cycle.
REQ-005 fetch_pc_i  input  32  PC of packet, 8-byte aligned.
REQ-006 fetch_instr_i  input  64  [31:0] instr at PC, [63:32] instr at PC+4.
REQ-007 fetch_ready_o  output  1  queue can accept a packet; fetch stage holds its PC when low.
REQ-008 flush_i  input  1  discard all queued packets (redirect).
REQ-009 dec_valid_o  output  1  head packet valid to decode.
REQ-010 dec_ready_i  input  1  decode consumes head this cycle.
REQ-011 dec_pc_o  output  32  head packet PC.
REQ-012 dec_instr0_o / dec_instr1_o  output  32 each  head instr at PC / PC+4.
REQ-013 count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage: DEPTH entries of {pc[31:0], instr[63:0]}; read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH; separate occupancy counter.
REQ-015 Push occurs on a clock edge when fetch_valid_i && fetch_ready_o && !flush_i; entry written at write pointer, pointer increments.
REQ-016 Pop occurs on a clock edge when dec_valid_o && dec_ready_i && !flush_i; read pointer increments.
REQ-017 fetch_ready_o SHALL equal (count_o != DEPTH), depending only on registered state; a pop in the same cycle does not make a full queue accept.
REQ-018 dec_valid_o SHALL equal (count_o != 0) except as modified by REQ-027.
REQ-019 dec_pc_o, dec_instr0_o, dec_instr1_o SHALL present the entry at the read pointer; they are don't-care while dec_valid_o is low.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance; legal at any non-full occupancy, including count 1.
REQ-021 Latency: a pushed packet is visible on dec_* on the cycle after the push edge.
REQ-022 Ordering: packets are delivered strictly in push order; no drop or duplication absent flush.
REQ-023 Flush: on the edge with flush_i high, both pointers and the count go to 0; the concurrent push and pop are both discarded; flush has priority over all other events.
REQ-024 The count never exceeds DEPTH and never underflows; dec_ready_i high while the queue is empty has no effect.

Reset
REQ-025 On the edge with reset_i high, pointers and count go to 0; hence fetch_ready_o=1, dec_valid_o=0, count_o=0 from the next cycle. Entry storage is not reset.
REQ-026 Reset asserted mid-operation behaves identically to flush and has priority over push, pop and flush.

Configuration
REQ-027 Macro FETCH_QUEUE_BYPASS_EN defined: when count_o==0 and fetch_valid_i is high, dec_valid_o is high in the same cycle and dec_* are driven directly from fetch_pc_i and fetch_instr_i. If dec_ready_i is also high and flush_i is low, the packet is consumed and not written, and the count stays 0. If dec_ready_i is low, the packet is written normally.
REQ-028 Macro not defined: no input-to-output combinational path exists and REQ-021 latency applies unconditionally.

Verification
REQ-029 Reset, then push pc=0x00,0x08,0x10,0x18 with dec_ready_i=0 -> count_o=4, fetch_ready_o=0; a fifth push attempt is ignored.
REQ-030 Full queue, dec_ready_i=1 and fetch_valid_i=1 for 1 cycle -> pop of pc=0x00 only, count_o=3, next cycle head pc=0x08.
REQ-031 Stream pc=0x100+8n with dec_ready_i=1 every cycle for 20 cycles (bypass off) -> count_o stays at 1 after the first cycle; PCs delivered in order with 1-cycle latency; pointers wrap at least 4 times.
REQ-032 Count 3, assert flush_i together with a push of pc=0x40 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, and 0x40 never appears.
REQ-033 Bypass defined, empty queue, push pc=0x200 with dec_ready_i=1 -> dec_valid_o=1 and dec_pc_o=0x200 in the same cycle, count_o remains 0.
REQ-034 Count 2, assert reset_i with push and pop active -> next cycle count_o=0, fetch_ready_o=1, dec_valid_o=0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order queue of fetch packets between the fetch and decode stages.
// Each entry holds {pc, instr pair}. Optional same-cycle bypass when the queue is
// empty is enabled by defining FETCH_QUEUE_BYPASS_EN; by default there is no
// combinational path from the fetch inputs to the outputs.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_pc_i,
  input  logic [63:0]                fetch_instr_i,
  output logic                       fetch_ready_o,
  input  logic                       flush_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [31:0]                dec_pc_o,
  output logic [31:0]                dec_instr0_o,
  output logic [31:0]                dec_instr1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc    [DEPTH];
  logic [63:0]   r_instr [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_byp_take;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Readiness depends only on registered occupancy, so a full queue never
  // accepts even if decode drains the head on the same edge.
  assign fetch_ready_o = !w_full;
  assign count_o       = r_count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_byp;
  // Empty queue: forward the incoming packet straight to decode.
  assign w_byp       = w_empty && fetch_valid_i;
  assign w_byp_take  = w_byp && dec_ready_i && !flush_i;
  assign dec_valid_o = !w_empty || w_byp;

  // Output mux: incoming packet while bypassing, otherwise the head entry.
  always_comb begin
    dec_pc_o     = r_pc[r_rptr];
    dec_instr0_o = r_instr[r_rptr][31:0];
    dec_instr1_o = r_instr[r_rptr][63:32];
    if (w_byp) begin
      dec_pc_o     = fetch_pc_i;
      dec_instr0_o = fetch_instr_i[31:0];
      dec_instr1_o = fetch_instr_i[63:32];
    end
  end
`else
  assign w_byp_take   = 1'b0;
  assign dec_valid_o  = !w_empty;
  assign dec_pc_o     = r_pc[r_rptr];
  assign dec_instr0_o = r_instr[r_rptr][31:0];
  assign dec_instr1_o = r_instr[r_rptr][63:32];
`endif

  // A bypassed packet that decode consumes is never written to storage.
  assign w_push = fetch_valid_i && !w_full && !flush_i && !w_byp_take;
  assign w_pop  = !w_empty && dec_ready_i && !flush_i;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is write-only on push and is deliberately not reset.
  always_ff @(posedge clock_i) begin
    if (w_push && !reset_i) begin
      r_pc[r_wptr]    <= fetch_pc_i;
      r_instr[r_wptr] <= fetch_instr_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. Expected packets are queued
// as they are driven and compared when the DUT presents them to decode.
// Honors FETCH_QUEUE_BYPASS_EN the same way the design does.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        fv;
  logic [31:0] fpc;
  logic [63:0] finstr;
  logic        fready;
  logic        flush;
  logic        dvalid;
  logic        dready;
  logic [31:0] dpc;
  logic [31:0] di0;
  logic [31:0] di1;
  logic [$clog2(DEPTH):0] cnt;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .fetch_valid_i (fv),
    .fetch_pc_i    (fpc),
    .fetch_instr_i (finstr),
    .fetch_ready_o (fready),
    .flush_i       (flush),
    .dec_valid_o   (dvalid),
    .dec_ready_i   (dready),
    .dec_pc_o      (dpc),
    .dec_instr0_o  (di0),
    .dec_instr1_o  (di1),
    .count_o       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] ins;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  bit   known = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_ins(input logic [31:0] pc);
    return {pc ^ 32'hDEAD_0004, ~pc};
  endfunction

  // One clock: drive at negedge, check outputs #1 later, advance model, step.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy,
                     input logic fl, input logic rs);
    logic [63:0] ins;
    bit          byp;
    bit          took;
    int          sz;
    ent_t        e;
    ins    = mk_ins(pc);
    fv     = v;
    fpc    = pc;
    finstr = ins;
    dready = rdy;
    flush  = fl;
    rst    = rs;
    #1;
    byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && v;
`endif
    if (known) begin
      chk("count", 64'(cnt), 64'(q.size()));
      chk("fready", 64'(fready), 64'(q.size() != DEPTH));
      chk("dvalid", 64'(dvalid), 64'(q.size() != 0 || byp));
      if (q.size() != 0) begin
        chk("dpc", 64'(dpc), 64'(q[0].pc));
        chk("di0", 64'(di0), 64'(q[0].ins[31:0]));
        chk("di1", 64'(di1), 64'(q[0].ins[63:32]));
      end else if (byp) begin
        chk("byp_pc", 64'(dpc), 64'(pc));
        chk("byp_i0", 64'(di0), 64'(ins[31:0]));
        chk("byp_i1", 64'(di1), 64'(ins[63:32]));
      end
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      sz   = q.size();
      took = 0;
      if (rdy && sz != 0) void'(q.pop_front());
      else if (rdy && byp) took = 1;
      if (v && sz != DEPTH && !took) begin
        e.pc  = pc;
        e.ins = ins;
        q.push_back(e);
      end
    end
    if (rs) known = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    fv = 0; fpc = '0; finstr = '0; dready = 0; flush = 0; rst = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Reset state, independent of the model.
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_rdy", 64'(fready), 64'd1);
    chk("rst_dv", 64'(dvalid), 64'd0);

    // Fill with decode stalled; fifth push must be ignored.
    for (int i = 0; i < 5; i++) cyc(1, 32'(i * 8), 0, 0, 0);
    chk("full_cnt", 64'(cnt), 64'd4);
    chk("full_rdy", 64'(fready), 64'd0);

    // Full queue: pop and push together -> only the pop happens.
    cyc(1, 32'h28, 1, 0, 0);
    chk("pop1_cnt", 64'(cnt), 64'd3);
    chk("pop1_pc", 64'(dpc), 64'h08);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);

    // Streaming through with decode always ready.
    for (int i = 0; i < 20; i++) cyc(1, 32'h100 + 32'(i * 8), 1, 0, 0);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("stream_cnt", 64'(cnt), 64'd1);
`endif
    cyc(0, 0, 1, 0, 0);

    // Flush at count 3 together with push and pop.
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 8), 0, 0, 0);
    cyc(1, 32'h40, 1, 1, 0);
    chk("flush_cnt", 64'(cnt), 64'd0);
    chk("flush_dv", 64'(dvalid), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);

    // Reset at count 2 with push and pop active.
    for (int i = 0; i < 2; i++) cyc(1, 32'h600 + 32'(i * 8), 0, 0, 0);
    cyc(1, 32'h610, 1, 0, 1);
    chk("rst2_cnt", 64'(cnt), 64'd0);
    chk("rst2_rdy", 64'(fready), 64'd1);
    chk("rst2_dv", 64'(dvalid), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with decode ready: packet passes straight through.
    fv = 1; fpc = 32'h200; finstr = mk_ins(32'h200); dready = 1; flush = 0; rst = 0;
    #1;
    chk("byp_dv", 64'(dvalid), 64'd1);
    chk("byp_pc0", 64'(dpc), 64'h200);
    cyc(1, 32'h200, 1, 0, 0);
    chk("byp_cnt", 64'(cnt), 64'd0);
`endif

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 8),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0, 0);
    chk("end_cnt", 64'(cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
